// File: rtl/match_count_display.sv
// Counts rising edges of a match strobe into a two-digit BCD register (00-99) and drives
// registered active-low seven-segment digits. Define COUNT_SATURATE_EN to stop at 99 instead of wrapping.
module match_count_display (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       clr,
    input  logic       match_in,
    output logic [7:0] count_bcd,
    output logic       wrap,
    output logic [7:0] DISP0,
    output logic [7:0] DISP1
);

    logic       r_match_q;
    logic [3:0] r_ones;
    logic [3:0] r_tens;
    logic       r_wrap;
    logic [7:0] r_disp0;
    logic [7:0] r_disp1;

    logic       w_edge;
    logic [3:0] w_ones_next;
    logic [3:0] w_tens_next;
    logic       w_wrap_next;
    logic [7:0] w_seg_ones;
    logic [7:0] w_seg_tens;

    // Segment order {dp,g,f,e,d,c,b,a}, active-low; dp stays off and non-BCD codes blank.
    function automatic logic [7:0] seg7(input logic [3:0] digit);
        logic [7:0] code;
        case (digit)
            4'd0:    code = 8'hC0;
            4'd1:    code = 8'hF9;
            4'd2:    code = 8'hA4;
            4'd3:    code = 8'hB0;
            4'd4:    code = 8'h99;
            4'd5:    code = 8'h92;
            4'd6:    code = 8'h82;
            4'd7:    code = 8'hF8;
            4'd8:    code = 8'h80;
            4'd9:    code = 8'h90;
            default: code = 8'hFF;
        endcase
        return code;
    endfunction

    assign w_edge = match_in & ~r_match_q;

    always_comb begin
        w_ones_next = r_ones;
        w_tens_next = r_tens;
        w_wrap_next = 1'b0;
        if (clr) begin
            w_ones_next = 4'd0;
            w_tens_next = 4'd0;
        end else if (ena && w_edge) begin
            if (r_ones == 4'd9 && r_tens == 4'd9) begin
`ifdef COUNT_SATURATE_EN
                w_ones_next = 4'd9;
                w_tens_next = 4'd9;
`else
                w_ones_next = 4'd0;
                w_tens_next = 4'd0;
                w_wrap_next = 1'b1;
`endif
            end else if (r_ones == 4'd9) begin
                w_ones_next = 4'd0;
                w_tens_next = r_tens + 4'd1;
            end else begin
                w_ones_next = r_ones + 4'd1;
            end
        end
    end

    // Tens digit suppresses its leading zero.
    assign w_seg_ones = seg7(r_ones);
    assign w_seg_tens = (r_tens == 4'd0) ? 8'hFF : seg7(r_tens);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_match_q <= 1'b0;
            r_ones    <= 4'd0;
            r_tens    <= 4'd0;
            r_wrap    <= 1'b0;
            r_disp0   <= 8'hC0;
            r_disp1   <= 8'hFF;
        end else begin
            r_match_q <= match_in;
            r_ones    <= w_ones_next;
            r_tens    <= w_tens_next;
            r_wrap    <= w_wrap_next;
            r_disp0   <= w_seg_ones;
            r_disp1   <= w_seg_tens;
        end
    end

    assign count_bcd = {r_tens, r_ones};
    assign wrap      = r_wrap;
    assign DISP0     = r_disp0;
    assign DISP1     = r_disp1;

endmodule

// File: tb/tb_match_count_display.sv
// Directed bench for match_count_display; covers both the wrapping and COUNT_SATURATE_EN builds.
module tb_match_count_display;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ena = 1'b1;
    logic       clr = 1'b0;
    logic       match_in = 1'b0;
    logic [7:0] count_bcd;
    logic       wrap;
    logic [7:0] DISP0;
    logic [7:0] DISP1;

    int n_cmp = 0;
    int n_bad = 0;

    match_count_display dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .clr       (clr),
        .match_in  (match_in),
        .count_bcd (count_bcd),
        .wrap      (wrap),
        .DISP0     (DISP0),
        .DISP1     (DISP1)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference segment table, hand-entered from the code list.
    function automatic logic [7:0] ref_seg(input int d);
        logic [7:0] tbl [10];
        tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        return tbl[d];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; ena = 1'b1; clr = 1'b0; match_in = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic pulse(output int wraps);
        wraps = 0;
        match_in = 1'b1;
        tick();
        if (wrap === 1'b1) wraps++;
        match_in = 1'b0;
        tick();
        if (wrap === 1'b1) wraps++;
    endtask

    task automatic pulses(input int n);
        int w;
        for (int i = 0; i < n; i++) pulse(w);
    endtask

    task automatic test_reset();
        do_reset();
        pulses(3);
        n_cmp++;
        if (count_bcd !== 8'h03) begin n_bad++; $display("FAIL pre_reset_count: got %h want 03", count_bcd); end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (count_bcd !== 8'h00) begin n_bad++; $display("FAIL reset_count: got %h want 00", count_bcd); end
        n_cmp++;
        if (wrap !== 1'b0) begin n_bad++; $display("FAIL reset_wrap: got %b want 0", wrap); end
        n_cmp++;
        if (DISP0 !== 8'hC0) begin n_bad++; $display("FAIL reset_disp0: got %h want C0", DISP0); end
        n_cmp++;
        if (DISP1 !== 8'hFF) begin n_bad++; $display("FAIL reset_disp1: got %h want FF", DISP1); end
        rst = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({count_bcd, DISP0, DISP1, wrap} !== {8'h00, 8'hC0, 8'hFF, 1'b0})
            begin n_bad++; $display("FAIL reset_hold: got %h %h %h %b want 00 C0 FF 0", count_bcd, DISP0, DISP1, wrap); end
    endtask

    task automatic test_single_held();
        do_reset();
        match_in = 1'b1;
        tick();
        match_in = 1'b0;
        n_cmp++;
        if (count_bcd !== 8'h01) begin n_bad++; $display("FAIL single_count: got %h want 01", count_bcd); end
        n_cmp++;
        if (DISP0 !== 8'hC0) begin n_bad++; $display("FAIL single_disp_lag: got %h want C0", DISP0); end
        tick();
        n_cmp++;
        if (DISP0 !== 8'hF9) begin n_bad++; $display("FAIL single_disp0: got %h want F9", DISP0); end
        n_cmp++;
        if (DISP1 !== 8'hFF) begin n_bad++; $display("FAIL single_disp1: got %h want FF", DISP1); end
        do_reset();
        match_in = 1'b1;
        repeat (20) tick();
        match_in = 1'b0;
        tick();
        n_cmp++;
        if (count_bcd !== 8'h01) begin n_bad++; $display("FAIL held_count: got %h want 01", count_bcd); end
    endtask

    task automatic test_carry();
        do_reset();
        pulses(10);
        n_cmp++;
        if ({count_bcd, DISP1, DISP0} !== {8'h10, 8'hF9, 8'hC0})
            begin n_bad++; $display("FAIL carry_10: got %h %h %h want 10 F9 C0", count_bcd, DISP1, DISP0); end
        pulses(25);
        n_cmp++;
        if ({count_bcd, DISP1, DISP0} !== {8'h35, 8'hB0, 8'h92})
            begin n_bad++; $display("FAIL carry_35: got %h %h %h want 35 B0 92", count_bcd, DISP1, DISP0); end
    endtask

    task automatic test_rollover();
        int w;
        int total;
        total = 0;
        do_reset();
        for (int i = 0; i < 99; i++) begin pulse(w); total += w; end
        n_cmp++;
        if (count_bcd !== 8'h99) begin n_bad++; $display("FAIL roll_99: got %h want 99", count_bcd); end
        match_in = 1'b1;
        tick();
        match_in = 1'b0;
`ifdef COUNT_SATURATE_EN
        n_cmp++;
        if ({count_bcd, wrap} !== {8'h99, 1'b0}) begin n_bad++; $display("FAIL sat_count: got %h %b want 99 0", count_bcd, wrap); end
`else
        n_cmp++;
        if ({count_bcd, wrap} !== {8'h00, 1'b1}) begin n_bad++; $display("FAIL wrap_count: got %h %b want 00 1", count_bcd, wrap); end
`endif
        if (wrap === 1'b1) total++;
        for (int i = 0; i < 3; i++) begin tick(); if (wrap === 1'b1) total++; end
`ifdef COUNT_SATURATE_EN
        n_cmp++;
        if (total !== 0) begin n_bad++; $display("FAIL sat_wrap_cycles: got %0d want 0", total); end
        n_cmp++;
        if ({count_bcd, DISP1, DISP0} !== {8'h99, 8'h90, 8'h90})
            begin n_bad++; $display("FAIL sat_disp: got %h %h %h want 99 90 90", count_bcd, DISP1, DISP0); end
`else
        n_cmp++;
        if (total !== 1) begin n_bad++; $display("FAIL wrap_cycles: got %0d want 1", total); end
        n_cmp++;
        if ({count_bcd, DISP1, DISP0} !== {8'h00, 8'hFF, 8'hC0})
            begin n_bad++; $display("FAIL wrap_disp: got %h %h %h want 00 FF C0", count_bcd, DISP1, DISP0); end
`endif
    endtask

    task automatic test_enable_clear();
        do_reset();
        pulses(3);
        ena = 1'b0;
        pulses(5);
        n_cmp++;
        if (count_bcd !== 8'h03) begin n_bad++; $display("FAIL ena_off: got %h want 03", count_bcd); end
        match_in = 1'b1;
        tick();
        ena = 1'b1;
        repeat (3) tick();
        match_in = 1'b0;
        tick();
        n_cmp++;
        if (count_bcd !== 8'h03) begin n_bad++; $display("FAIL ena_late_level: got %h want 03", count_bcd); end
        do_reset();
        pulses(42);
        n_cmp++;
        if ({count_bcd, DISP1, DISP0} !== {8'h42, 8'h99, 8'hA4})
            begin n_bad++; $display("FAIL clr_pre: got %h %h %h want 42 99 A4", count_bcd, DISP1, DISP0); end
        match_in = 1'b1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_cmp++;
        if ({count_bcd, wrap, DISP0} !== {8'h00, 1'b0, 8'hA4})
            begin n_bad++; $display("FAIL clr_count: got %h %b %h want 00 0 A4", count_bcd, wrap, DISP0); end
        tick();
        match_in = 1'b0;
        n_cmp++;
        if ({DISP0, DISP1} !== {8'hC0, 8'hFF}) begin n_bad++; $display("FAIL clr_disp: got %h %h want C0 FF", DISP0, DISP1); end
        tick();
        n_cmp++;
        if (count_bcd !== 8'h00) begin n_bad++; $display("FAIL clr_edge_dropped: got %h want 00", count_bcd); end
    endtask

    task automatic test_stream();
        logic [23:0] stream;
        logic        prev;
        int          model;
        int          model_old;
        logic [7:0]  exp_d1;
        stream = 24'b000100110001011101010011;
        prev = 1'b0;
        model = 0;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            model_old = model;
            match_in = stream[i];
            tick();
            if (stream[i] && !prev) model++;
            prev = stream[i];
            n_cmp++;
            if (count_bcd !== 8'((model / 10) * 16 + model % 10))
                begin n_bad++; $display("FAIL stream_count[%0d]: got %h want %0d", i, count_bcd, model); end
            exp_d1 = (model_old / 10 == 0) ? 8'hFF : ref_seg(model_old / 10);
            n_cmp++;
            if ({DISP1, DISP0} !== {exp_d1, ref_seg(model_old % 10)})
                begin n_bad++; $display("FAIL stream_disp[%0d]: got %h %h want %h %h", i, DISP1, DISP0, exp_d1, ref_seg(model_old % 10)); end
        end
        match_in = 1'b0;
        tick();
        n_cmp++;
        if (count_bcd !== 8'h07) begin n_bad++; $display("FAIL stream_total: got %h want 07", count_bcd); end
    endtask

    initial begin
        test_reset();
        test_single_held();
        test_carry();
        test_rollover();
        test_enable_clear();
        test_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/match_count_display.md
# match_count_display

Downstream consumer of the sequence detector's match output. Counts rising edges of the one-bit match signal in a two-digit BCD register (00–99) and drives two registered, active-low seven-segment digits for the board display. The tens digit is blanked below 10. The block owns all counting and display encoding, so the detector only produces a match strobe.

## Interface
Parameters:
- none. Width and encoding are fixed: two BCD digits, 8-bit segment bus.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset; one clock domain only
- ena  in  1  count enable; when 0, edges are ignored and not remembered
- clr  in  1  synchronous clear of count and displays
- match_in  in  1  match strobe from detector, may be a pulse or a held level
- count_bcd  out  8  {tens[3:0], ones[3:0]} BCD count
- wrap  out  1  one-cycle pulse on 99→00 rollover
- DISP0  out  8  ones digit segments {dp,g,f,e,d,c,b,a}, active-low
- DISP1  out  8  tens digit segments, same format

## Operation
- Edge detect: match_q is a register that follows match_in every cycle, regardless of ena or clr. edge = match_in & ~match_q. A held level counts once.
- Count update, priority highest first:
  - clr: count = 00, wrap = 0.
  - ena & edge: ones+1. If ones = 9, ones = 0 and tens+1.
  - At 99: behaviour depends on Configuration.
  - otherwise: hold.
- ena = 0 discards edges. An edge that occurs while disabled is never counted later.
- Digits are always valid BCD (0–9). Values 10–15 are unreachable. If one occurs, the decoder outputs blank 0xFF.
- Segment codes, active-low:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99
  - 5=92, 6=82, 7=F8, 8=80, 9=90
  - blank=FF; dp is always 1 (off)
- DISP1 shows FF when tens = 0 (leading-zero blank). DISP0 always shows a digit.

## Timing
- Reset (rst low, asynchronous) sets:
  - count_bcd = 00, wrap = 0, match_q = 0
  - DISP0 = C0, DISP1 = FF
- Outputs hold these values until the first rising clk after rst is released.
- Edge sampled at clk edge N: count_bcd and wrap change after edge N. DISP0/DISP1 reflect the new count after edge N+1 (one-cycle display register).
- wrap is high for exactly one cycle, the cycle after edge N. Its display update lags by one cycle like the digits.
- clr at edge N: count = 00 after N, displays C0/FF after N+1. An edge in the same cycle is discarded.
- Back-to-back edges need match_in low for at least one cycle between them. Max count rate is one per two cycles.
- Reset mid-count: immediate asynchronous return to reset values. No partial update.

## Configuration
- COUNT_SATURATE_EN defined: count stops at 99. Further edges leave 99, and wrap is tied to 0.
- COUNT_SATURATE_EN undefined (default): 99 + edge → 00, with wrap pulsing one cycle.

## Test plan
- Reset: assert rst low mid-run -> count_bcd=00, DISP0=C0, DISP1=FF, wrap=0 immediately. Release, no match -> values held.
- Single and held match: one 1-cycle pulse -> count_bcd=01, DISP0=F9 one cycle later, DISP1=FF. Hold match_in high 20 cycles -> count stays 01 after the first increment.
- Carry: 10 separated pulses -> count_bcd=10, DISP1=F9, DISP0=C0. 35 pulses -> 35, DISP1=B0, DISP0=92.
- Rollover: 100 pulses. Default -> count_bcd=00, wrap high exactly one cycle, DISP1=FF. With COUNT_SATURATE_EN -> 99, DISP1=DISP0=90, wrap never high.
- Enable/clear priority:
  - ena=0 with 5 pulses -> count unchanged.
  - match_in rising while ena=0, then ena=1 with the level still held -> no increment.
  - clr coincident with an edge at count 42 -> 00, displays C0/FF.
- Detector stream: feed the 24-bit test stream 000100110001011101010011 (bit 0 first) through the detector -> final count_bcd equals the detector's match count, with display encodings consistent at every cycle.
